// File: rtl/fetch_ctrl_if.sv
// Fetch-side bundle: imem port-B read channel, redirect/halt control and the
// valid/ready handoff to decode. The fetch controller takes the master side.
interface fetch_ctrl_if #(
    parameter int IMEM_AW = 14
);
    logic [IMEM_AW-1:0] imem_addrb;
    logic [31:0]        imem_doutb;
    logic               redirect_valid;
    logic [31:0]        redirect_pc;
    logic               halt;
    logic               out_valid;
    logic               out_ready;
    logic [31:0]        out_pc;
    logic [31:0]        out_inst;
    logic               busy;

    modport master (
        output imem_addrb,
        input  imem_doutb,
        input  redirect_valid,
        input  redirect_pc,
        input  halt,
        output out_valid,
        input  out_ready,
        output out_pc,
        output out_inst,
        output busy
    );

    modport slave (
        input  imem_addrb,
        output imem_doutb,
        output redirect_valid,
        output redirect_pc,
        output halt,
        input  out_valid,
        output out_ready,
        input  out_pc,
        input  out_inst,
        input  busy
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one imem read per cycle and
// hides the 1-cycle read latency behind a 2-entry {pc, inst} output buffer.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 14
) (
    input  logic          clk,
    input  logic          rst,
    fetch_ctrl_if.master  bus
);
    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] tag_q;
    logic        inflight_q;
    logic [1:0]  count_q;
    logic [1:0]  count_d;
    logic        rd_ptr_q;
    logic        wr_ptr_q;

    logic [1:0][31:0] ent_pc;
    logic [1:0][31:0] ent_inst;

    logic        redirect;
    logic        pop;
    logic        push;
    logic        issue;
    logic [2:0]  occupancy;
    logic [31:0] target_pc;
    logic [31:0] fetch_pc;
    logic        unused_ok;

    assign unused_ok = ^bus.redirect_pc[1:0];

    // BOOT ignores redirects so nothing can be fetched before the pipeline is live.
    assign redirect  = bus.redirect_valid & (state_q != BOOT);
    assign pop       = bus.out_valid & bus.out_ready;
    assign push      = inflight_q & ~redirect;
    assign target_pc = {bus.redirect_pc[31:2], 2'b00};
    assign fetch_pc  = redirect ? target_pc : pc_q;

    // Slots committed after this cycle: buffered + returning - leaving.
    assign occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};

    always_comb begin
        issue = 1'b0;
        if (state_q == RUN) begin
            if (redirect) begin
                issue = 1'b1;
            end else begin
                issue = (occupancy < 3'd2);
            end
        end
    end

    always_comb begin
        count_d = count_q;
        if (redirect) begin
            count_d = 2'd0;
        end else begin
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    assign bus.imem_addrb = fetch_pc[IMEM_AW+1:2];
    assign bus.out_valid  = (count_q != 2'd0);
    assign bus.busy       = inflight_q | (count_q != 2'd0);
    assign bus.out_pc     = ent_pc[rd_ptr_q];
    assign bus.out_inst   = ent_inst[rd_ptr_q];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            tag_q      <= 32'd0;
            inflight_q <= 1'b0;
            count_q    <= 2'd0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
        end else begin
            case (state_q)
                BOOT:    state_q <= bus.halt ? HALTED : RUN;
                RUN:     state_q <= bus.halt ? HALTED : RUN;
                HALTED:  state_q <= bus.halt ? HALTED : RUN;
                default: state_q <= BOOT;
            endcase

            if (issue) begin
                tag_q <= fetch_pc;
                pc_q  <= fetch_pc + 32'd4;
            end else if (redirect) begin
                pc_q  <= target_pc;
            end
            inflight_q <= issue;
            count_q    <= count_d;

            // A flush restarts both pointers; any pop this cycle is already visible to decode.
            if (redirect) begin
                rd_ptr_q <= 1'b0;
                wr_ptr_q <= 1'b0;
            end else begin
                if (pop) begin
                    rd_ptr_q <= ~rd_ptr_q;
                end
                if (push) begin
                    wr_ptr_q <= ~wr_ptr_q;
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ent
            logic [31:0] pc_q;
            logic [31:0] inst_q;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    pc_q   <= 32'd0;
                    inst_q <= 32'd0;
                end else if (push && (wr_ptr_q == gi[0])) begin
                    pc_q   <= tag_q;
                    inst_q <= bus.imem_doutb;
                end
            end

            assign ent_pc[gi]   = pc_q;
            assign ent_inst[gi] = inst_q;
        end
    endgenerate

    a_no_push_when_full: assert property (
        @(posedge clk) disable iff (!rst) !(push && (count_q == 2'd2))
    );
endmodule
